axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- Synthesizable AXI4 slave memory model: the responder end of the MIG AXI port driven by the FIFO controller.
- Used in testbenches and in MIG-less bring-up builds in place of the DDR controller.
- Backs a single-clock word-addressed RAM and generates the calibration-done flag the controller waits on.
- Write and read channels run as independent FSMs, each with one outstanding burst.

Parameters:
MIG_Port_Size, 128, data width in bits (64/128/256/512)
Mem_Depth, 1024, RAM depth in MIG_Port_Size words
Base_Address, 0, byte address mapped to word 0
Calib_Cycles, 16, cycles from reset release to init_calib high

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
init_calib  out  1  calibration done; high Calib_Cycles cycles after reset release
MIG_Port_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  4/32/8/3/2/1  write address
MIG_Port_AWREADY  out  1  write address accept
MIG_Port_WDATA/WSTRB/WLAST/WVALID  in  MIG_Port_Size/MIG_Port_Size/8/1/1  write data
MIG_Port_WREADY  out  1  write data accept
MIG_Port_BID/BRESP/BVALID  out  4/2/1  write response
MIG_Port_BREADY  in  1  response accept
MIG_Port_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  4/32/8/3/2/1  read address
MIG_Port_ARREADY  out  1  read address accept
MIG_Port_RID/RDATA/RRESP/RLAST/RVALID  out  4/MIG_Port_Size/2/1/1  read data
MIG_Port_RREADY  in  1  read data accept
MIG_Port_AW/AR REGION,LOCK,CACHE,PROT,QOS  in  standard widths  accepted and ignored

Behaviour:
- Reset: all outputs 0; FSMs to IDLE; calib counter cleared. RAM contents are retained across reset.
- init_calib:
  - Counter increments each cycle after reset release.
  - init_calib is registered high when the count reaches Calib_Cycles and stays high until reset.
  - AWREADY and ARREADY are 0 while init_calib is 0.
- Address decode:
  - word = (ADDR - Base_Address) >> log2(MIG_Port_Size/8).
  - A beat is out of range if ADDR < Base_Address or word >= Mem_Depth.
  - Beat n of a burst uses word0 + n (INCR only).
- Bursts with AxBURST != INCR or AxSIZE != log2(MIG_Port_Size/8) are accepted, execute as INCR full-width, and respond SLVERR (2'b10).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1 once calibrated. On AWVALID&AWREADY, latch ID/addr/LEN, clear beat counter, go W_DATA; AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the bytes enabled by WSTRB to RAM; out-of-range beats are dropped.
  - W_DATA exit: on the beat with WLAST=1, go W_RESP. If WLAST arrives with beat counter != LEN, or the LEN beat lacks WLAST, flag SLVERR; W_DATA keeps consuming until WLAST.
  - W_RESP: BVALID=1 with BID = latched ID. BRESP priority: DECERR (2'b11) if any beat was out of range, else SLVERR if flagged, else OKAY. Hold until BREADY, then go W_IDLE.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1 once calibrated. On handshake, latch ID/addr/LEN and go R_FETCH.
  - R_FETCH: one cycle for the synchronous RAM read. First RVALID appears 2 cycles after the AR handshake.
  - R_DATA: RVALID=1; RID = latched ID; RLAST=1 only on beat LEN.
  - RDATA/RRESP/RLAST are held stable while RVALID&!RREADY. With RREADY held high, beats issue back-to-back, one per cycle, via a lookahead RAM address.
  - Out-of-range beats return RDATA=0 with RRESP=DECERR; other beats return OKAY, or SLVERR per the burst-type rule.
  - After the RLAST handshake, go R_IDLE; ARREADY is high the next cycle.
- Simultaneous write beat and read fetch of the same word: read returns the pre-write data.
- LEN=0 gives a single beat with RLAST/WLAST on beat 0. LEN=255 is supported; the 8-bit beat counter must not wrap early.
- Reset asserted mid-burst: bursts are abandoned immediately; no B or R beats are produced for them after release.

Test Plan:
- Reset release, Calib_Cycles=16: init_calib rises on cycle 16; AWVALID held high from cycle 0 sees AWREADY=0 until init_calib=1.
- Write AWADDR=0x40, AWLEN=3 (128-bit), data 1..4, WSTRB all ones -> BRESP=OKAY, BID echoed. Then read ARADDR=0x40, ARLEN=3 -> RDATA 1,2,3,4; RLAST on beat 3; first RVALID 2 cycles after AR handshake.
- Partial-strobe write WSTRB=0x000F of 0xFFFF...F over 0 -> word reads back 0x...0000FFFFFFFF.
- Read with RREADY toggled 1,0,0,1 -> RDATA/RLAST stable during stalls; no beat lost or duplicated.
- Write at word Mem_Depth-1, AWLEN=1 -> BRESP=DECERR; word Mem_Depth-1 is updated. Read of the same burst -> beat 1 returns RDATA=0, RRESP=DECERR.
- WLAST asserted on beat 1 of AWLEN=3 -> BRESP=SLVERR. Assert aresetn=0 mid-read-burst -> RVALID=0 immediately; after recalibration a fresh read works.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model standing in for the MIG DDR controller: word-addressed RAM,
// independent single-outstanding write/read burst engines and a calibration-done timer.
module axi_mem_responder #(
    parameter int          MIG_Port_Size = 128,
    parameter int          Mem_Depth     = 1024,
    parameter logic [31:0] Base_Address  = 32'h0,
    parameter int          Calib_Cycles  = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    output logic                       init_calib,

    input  logic [3:0]                 MIG_Port_AWID,
    input  logic [31:0]                MIG_Port_AWADDR,
    input  logic [7:0]                 MIG_Port_AWLEN,
    input  logic [2:0]                 MIG_Port_AWSIZE,
    input  logic [1:0]                 MIG_Port_AWBURST,
    input  logic [3:0]                 MIG_Port_AWREGION,
    input  logic                       MIG_Port_AWLOCK,
    input  logic [3:0]                 MIG_Port_AWCACHE,
    input  logic [2:0]                 MIG_Port_AWPROT,
    input  logic [3:0]                 MIG_Port_AWQOS,
    input  logic                       MIG_Port_AWVALID,
    output logic                       MIG_Port_AWREADY,

    input  logic [MIG_Port_Size-1:0]   MIG_Port_WDATA,
    input  logic [MIG_Port_Size/8-1:0] MIG_Port_WSTRB,
    input  logic                       MIG_Port_WLAST,
    input  logic                       MIG_Port_WVALID,
    output logic                       MIG_Port_WREADY,

    output logic [3:0]                 MIG_Port_BID,
    output logic [1:0]                 MIG_Port_BRESP,
    output logic                       MIG_Port_BVALID,
    input  logic                       MIG_Port_BREADY,

    input  logic [3:0]                 MIG_Port_ARID,
    input  logic [31:0]                MIG_Port_ARADDR,
    input  logic [7:0]                 MIG_Port_ARLEN,
    input  logic [2:0]                 MIG_Port_ARSIZE,
    input  logic [1:0]                 MIG_Port_ARBURST,
    input  logic [3:0]                 MIG_Port_ARREGION,
    input  logic                       MIG_Port_ARLOCK,
    input  logic [3:0]                 MIG_Port_ARCACHE,
    input  logic [2:0]                 MIG_Port_ARPROT,
    input  logic [3:0]                 MIG_Port_ARQOS,
    input  logic                       MIG_Port_ARVALID,
    output logic                       MIG_Port_ARREADY,

    output logic [3:0]                 MIG_Port_RID,
    output logic [MIG_Port_Size-1:0]   MIG_Port_RDATA,
    output logic [1:0]                 MIG_Port_RRESP,
    output logic                       MIG_Port_RLAST,
    output logic                       MIG_Port_RVALID,
    input  logic                       MIG_Port_RREADY
);

    localparam int BYTES = MIG_Port_Size / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int AW    = (Mem_Depth > 1) ? $clog2(Mem_Depth) : 1;
    localparam int CW    = $clog2(Calib_Cycles + 1) + 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;
    localparam logic [1:0] RESP_DEC   = 2'b11;
    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic logic [32:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - Base_Address;
        return {1'b0, off >> SHIFT};
    endfunction

    function automatic logic beat_oor(input logic base_oor, input logic [32:0] word);
        return base_oor || (word >= 33'(Mem_Depth));
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return (burst != BURST_INCR) || (size != 3'(SHIFT));
    endfunction

    // Decode errors outrank protocol/burst-type errors.
    function automatic logic [1:0] resp_of(input logic oor, input logic err);
        return oor ? RESP_DEC : (err ? RESP_SLV : RESP_OKAY);
    endfunction

    logic [MIG_Port_Size-1:0] mem [0:Mem_Depth-1];

    logic unused_sideband;
    assign unused_sideband = ^{MIG_Port_AWREGION, MIG_Port_AWLOCK, MIG_Port_AWCACHE,
                               MIG_Port_AWPROT, MIG_Port_AWQOS, MIG_Port_ARREGION,
                               MIG_Port_ARLOCK, MIG_Port_ARCACHE, MIG_Port_ARPROT,
                               MIG_Port_ARQOS};

    logic [CW-1:0] calib_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            calib_cnt  <= '0;
            init_calib <= 1'b0;
        end else if (!init_calib) begin
            calib_cnt <= calib_cnt + 1'b1;
            if (calib_cnt == CW'(Calib_Cycles - 1))
                init_calib <= 1'b1;
        end
    end

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t    w_state, w_state_nxt;
    logic [32:0] w_word;
    logic        w_base_oor, w_err, w_oor;
    logic [7:0]  w_len, w_cnt;
    logic        aw_hs, w_hs, w_beat_oor, w_beat_err;

    assign aw_hs      = MIG_Port_AWVALID && MIG_Port_AWREADY;
    assign w_hs       = MIG_Port_WVALID && MIG_Port_WREADY;
    assign w_beat_oor = beat_oor(w_base_oor, w_word);
    assign w_beat_err = (MIG_Port_WLAST && (w_cnt != w_len)) ||
                        ((w_cnt == w_len) && !MIG_Port_WLAST);

    always_comb begin
        w_state_nxt      = w_state;
        MIG_Port_AWREADY = 1'b0;
        MIG_Port_WREADY  = 1'b0;
        MIG_Port_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                MIG_Port_AWREADY = init_calib;
                if (MIG_Port_AWVALID && init_calib) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                MIG_Port_WREADY = 1'b1;
                if (MIG_Port_WVALID && MIG_Port_WLAST) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                MIG_Port_BVALID = 1'b1;
                if (MIG_Port_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state        <= W_IDLE;
            MIG_Port_BID   <= '0;
            MIG_Port_BRESP <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) MIG_Port_BID <= MIG_Port_AWID;
            if (w_hs && MIG_Port_WLAST)
                MIG_Port_BRESP <= resp_of(w_oor || w_beat_oor, w_err || w_beat_err);
        end
    end

    // Burst context is fully reloaded on every AW handshake, so it needs no reset.
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_word     <= word_of(MIG_Port_AWADDR);
            w_base_oor <= MIG_Port_AWADDR < Base_Address;
            w_len      <= MIG_Port_AWLEN;
            w_cnt      <= '0;
            w_err      <= burst_bad(MIG_Port_AWBURST, MIG_Port_AWSIZE);
            w_oor      <= 1'b0;
        end else if (w_hs) begin
            w_word <= w_word + 33'd1;
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err || w_beat_err;
            w_oor  <= w_oor || w_beat_oor;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_beat_oor) begin
            for (int b = 0; b < BYTES; b++) begin
                if (MIG_Port_WSTRB[b])
                    mem[w_word[AW-1:0]][b*8 +: 8] <= MIG_Port_WDATA[b*8 +: 8];
            end
        end
    end

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    r_state_t                 r_state, r_state_nxt;
    logic [32:0]              r_word;
    logic                     r_base_oor, r_err, r_oor_q, r_last, rd_en, rd_oor, ar_hs;
    logic [7:0]               r_len, r_cnt;
    logic [MIG_Port_Size-1:0] ram_q;

    assign ar_hs  = MIG_Port_ARVALID && MIG_Port_ARREADY;
    assign r_last = (r_cnt == r_len);
    assign rd_oor = beat_oor(r_base_oor, r_word);

    // r_word runs one beat ahead of the presented beat so an accepted beat is
    // replaced by the next one on the following cycle.
    always_comb begin
        r_state_nxt      = r_state;
        MIG_Port_ARREADY = 1'b0;
        MIG_Port_RVALID  = 1'b0;
        rd_en            = 1'b0;
        case (r_state)
            R_IDLE: begin
                MIG_Port_ARREADY = init_calib;
                if (MIG_Port_ARVALID && init_calib) r_state_nxt = R_FETCH;
            end
            R_FETCH: begin
                rd_en       = 1'b1;
                r_state_nxt = R_DATA;
            end
            R_DATA: begin
                MIG_Port_RVALID = 1'b1;
                if (MIG_Port_RREADY) begin
                    if (r_last) r_state_nxt = R_IDLE;
                    else        rd_en       = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= R_IDLE;
            MIG_Port_RID <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) MIG_Port_RID <= MIG_Port_ARID;
        end
    end

    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_word     <= word_of(MIG_Port_ARADDR);
            r_base_oor <= MIG_Port_ARADDR < Base_Address;
            r_len      <= MIG_Port_ARLEN;
            r_cnt      <= '0;
            r_err      <= burst_bad(MIG_Port_ARBURST, MIG_Port_ARSIZE);
        end else if (rd_en) begin
            r_word  <= r_word + 33'd1;
            r_oor_q <= rd_oor;
            if (r_state == R_DATA) r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rd_en && !rd_oor)
            ram_q <= mem[r_word[AW-1:0]];
    end

    assign MIG_Port_RDATA = (r_state == R_DATA && !r_oor_q) ? ram_q : '0;
    assign MIG_Port_RRESP = (r_state == R_DATA) ? resp_of(r_oor_q, r_err) : RESP_OKAY;
    assign MIG_Port_RLAST = (r_state == R_DATA) && r_last;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a transaction-level memory model predicts every
// B and R beat, plus literal expectations for the scenarios of interest.
module tb_axi_mem_responder;

    localparam int          DW    = 128;
    localparam int          DEPTH = 1024;
    localparam int          CALIB = 16;
    localparam logic [31:0] BASE  = 32'h0;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic          init_calib;
    logic [3:0]    MIG_Port_AWID = '0;
    logic [31:0]   MIG_Port_AWADDR = '0;
    logic [7:0]    MIG_Port_AWLEN = '0;
    logic [2:0]    MIG_Port_AWSIZE = 3'd4;
    logic [1:0]    MIG_Port_AWBURST = 2'b01;
    logic          MIG_Port_AWVALID = 1'b0;
    logic          MIG_Port_AWREADY;
    logic [DW-1:0] MIG_Port_WDATA = '0;
    logic [15:0]   MIG_Port_WSTRB = '0;
    logic          MIG_Port_WLAST = 1'b0;
    logic          MIG_Port_WVALID = 1'b0;
    logic          MIG_Port_WREADY;
    logic [3:0]    MIG_Port_BID;
    logic [1:0]    MIG_Port_BRESP;
    logic          MIG_Port_BVALID;
    logic          MIG_Port_BREADY = 1'b0;
    logic [3:0]    MIG_Port_ARID = '0;
    logic [31:0]   MIG_Port_ARADDR = '0;
    logic [7:0]    MIG_Port_ARLEN = '0;
    logic [2:0]    MIG_Port_ARSIZE = 3'd4;
    logic [1:0]    MIG_Port_ARBURST = 2'b01;
    logic          MIG_Port_ARVALID = 1'b0;
    logic          MIG_Port_ARREADY;
    logic [3:0]    MIG_Port_RID;
    logic [DW-1:0] MIG_Port_RDATA;
    logic [1:0]    MIG_Port_RRESP;
    logic          MIG_Port_RLAST;
    logic          MIG_Port_RVALID;
    logic          MIG_Port_RREADY = 1'b0;

    axi_mem_responder #(
        .MIG_Port_Size(DW), .Mem_Depth(DEPTH), .Base_Address(BASE), .Calib_Cycles(CALIB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .init_calib(init_calib),
        .MIG_Port_AWID(MIG_Port_AWID), .MIG_Port_AWADDR(MIG_Port_AWADDR),
        .MIG_Port_AWLEN(MIG_Port_AWLEN), .MIG_Port_AWSIZE(MIG_Port_AWSIZE),
        .MIG_Port_AWBURST(MIG_Port_AWBURST), .MIG_Port_AWREGION(4'h0),
        .MIG_Port_AWLOCK(1'b0), .MIG_Port_AWCACHE(4'h0), .MIG_Port_AWPROT(3'h0),
        .MIG_Port_AWQOS(4'h0), .MIG_Port_AWVALID(MIG_Port_AWVALID),
        .MIG_Port_AWREADY(MIG_Port_AWREADY),
        .MIG_Port_WDATA(MIG_Port_WDATA), .MIG_Port_WSTRB(MIG_Port_WSTRB),
        .MIG_Port_WLAST(MIG_Port_WLAST), .MIG_Port_WVALID(MIG_Port_WVALID),
        .MIG_Port_WREADY(MIG_Port_WREADY),
        .MIG_Port_BID(MIG_Port_BID), .MIG_Port_BRESP(MIG_Port_BRESP),
        .MIG_Port_BVALID(MIG_Port_BVALID), .MIG_Port_BREADY(MIG_Port_BREADY),
        .MIG_Port_ARID(MIG_Port_ARID), .MIG_Port_ARADDR(MIG_Port_ARADDR),
        .MIG_Port_ARLEN(MIG_Port_ARLEN), .MIG_Port_ARSIZE(MIG_Port_ARSIZE),
        .MIG_Port_ARBURST(MIG_Port_ARBURST), .MIG_Port_ARREGION(4'h0),
        .MIG_Port_ARLOCK(1'b0), .MIG_Port_ARCACHE(4'h0), .MIG_Port_ARPROT(3'h0),
        .MIG_Port_ARQOS(4'h0), .MIG_Port_ARVALID(MIG_Port_ARVALID),
        .MIG_Port_ARREADY(MIG_Port_ARREADY),
        .MIG_Port_RID(MIG_Port_RID), .MIG_Port_RDATA(MIG_Port_RDATA),
        .MIG_Port_RRESP(MIG_Port_RRESP), .MIG_Port_RLAST(MIG_Port_RLAST),
        .MIG_Port_RVALID(MIG_Port_RVALID), .MIG_Port_RREADY(MIG_Port_RREADY)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]    id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic          chk;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t        rq[$];
    bexp_t         bq[$];
    logic [DW-1:0] mmem [DEPTH];
    bit            mval [DEPTH];
    int            calib_edges = 0;

    longint     mw_word0;
    int         mw_cnt, mw_len;
    bit         mw_base_oor, mw_err, mw_oor;
    logic [3:0] mw_id;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) calib_edges <= 0;
        else          calib_edges <= calib_edges + 1;
    end

    function automatic longint word_at(input logic [31:0] addr);
        return longint'((addr - BASE) >> 4);
    endfunction

    always @(negedge aclk) begin
        rbeat_t rb;
        bexp_t  be;
        longint w;
        bit     oor, berr;
        if (!aresetn) begin
            rq.delete();
            bq.delete();
            check_int("rst_ctrl", int'({init_calib, MIG_Port_AWREADY, MIG_Port_WREADY,
                      MIG_Port_BID, MIG_Port_BRESP, MIG_Port_BVALID, MIG_Port_ARREADY,
                      MIG_Port_RID, MIG_Port_RRESP, MIG_Port_RLAST, MIG_Port_RVALID}), 0);
            check("rst_rdata", MIG_Port_RDATA, '0);
        end else begin
            check_int("init_calib", int'(init_calib), int'(calib_edges >= CALIB));
            if (!init_calib)
                check_int("ready_precal", int'({MIG_Port_AWREADY, MIG_Port_ARREADY}), 0);
            if (MIG_Port_BVALID) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got BVALID=1, expected no response");
                end else begin
                    check_int("bid", int'(MIG_Port_BID), int'(bq[0].id));
                    check_int("bresp", int'(MIG_Port_BRESP), int'(bq[0].resp));
                    if (MIG_Port_BREADY) void'(bq.pop_front());
                end
            end
            if (MIG_Port_RVALID) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got RVALID=1, expected no beat");
                end else begin
                    rb = rq[0];
                    check_int("rid", int'(MIG_Port_RID), int'(rb.id));
                    check_int("rresp", int'(MIG_Port_RRESP), int'(rb.resp));
                    check_int("rlast", int'(MIG_Port_RLAST), int'(rb.last));
                    if (rb.chk) check("rdata", MIG_Port_RDATA, rb.data);
                    if (MIG_Port_RREADY) void'(rq.pop_front());
                end
            end
            if (MIG_Port_AWVALID && MIG_Port_AWREADY) begin
                mw_id       = MIG_Port_AWID;
                mw_word0    = word_at(MIG_Port_AWADDR);
                mw_base_oor = MIG_Port_AWADDR < BASE;
                mw_len      = int'(MIG_Port_AWLEN);
                mw_cnt      = 0;
                mw_err      = (MIG_Port_AWBURST != 2'b01) || (MIG_Port_AWSIZE != 3'd4);
                mw_oor      = 0;
            end
            if (MIG_Port_WVALID && MIG_Port_WREADY) begin
                w = mw_word0 + mw_cnt;
                oor = mw_base_oor || (w >= DEPTH);
                if (!oor) begin
                    for (int b = 0; b < 16; b++)
                        if (MIG_Port_WSTRB[b]) mmem[int'(w)][b*8 +: 8] = MIG_Port_WDATA[b*8 +: 8];
                    mval[int'(w)] = mval[int'(w)] | (&MIG_Port_WSTRB);
                end
                mw_oor = mw_oor | oor;
                if (MIG_Port_WLAST != (mw_cnt == mw_len)) mw_err = 1;
                mw_cnt++;
                if (MIG_Port_WLAST) begin
                    be.id   = mw_id;
                    be.resp = mw_oor ? 2'b11 : (mw_err ? 2'b10 : 2'b00);
                    bq.push_back(be);
                end
            end
            if (MIG_Port_ARVALID && MIG_Port_ARREADY) begin
                berr = (MIG_Port_ARBURST != 2'b01) || (MIG_Port_ARSIZE != 3'd4);
                for (int n = 0; n <= int'(MIG_Port_ARLEN); n++) begin
                    w = word_at(MIG_Port_ARADDR) + n;
                    oor = (MIG_Port_ARADDR < BASE) || (w >= DEPTH);
                    rb.id   = MIG_Port_ARID;
                    rb.data = oor ? '0 : mmem[int'(w)];
                    rb.chk  = oor ? 1'b1 : mval[int'(w)];
                    rb.resp = oor ? 2'b11 : (berr ? 2'b10 : 2'b00);
                    rb.last = (n == int'(MIG_Port_ARLEN));
                    rq.push_back(rb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic sig_of(input int k);
        case (k)
            0:       return MIG_Port_AWREADY;
            1:       return MIG_Port_WREADY;
            2:       return MIG_Port_BVALID;
            default: return MIG_Port_ARREADY;
        endcase
    endfunction

    task automatic wait_sig(input int k, input string name);
        int n = 0;
        @(negedge aclk);
        while (!sig_of(k) && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!sig_of(k)) begin
            checks++; errors++;
            $display("FAIL %s_timeout: waited %0d cycles, expected handshake", name, n);
        end
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int nbeats, input logic [DW-1:0] d0, input logic [15:0] strb,
                            input logic [1:0] burst, output logic [1:0] resp);
        MIG_Port_AWID = id; MIG_Port_AWADDR = addr; MIG_Port_AWLEN = len;
        MIG_Port_AWBURST = burst; MIG_Port_AWSIZE = 3'd4; MIG_Port_AWVALID = 1'b1;
        wait_sig(0, "aw");
        tick();
        MIG_Port_AWVALID = 1'b0;
        for (int n = 0; n < nbeats; n++) begin
            MIG_Port_WDATA = d0 + DW'(n); MIG_Port_WSTRB = strb;
            MIG_Port_WLAST = (n == nbeats - 1); MIG_Port_WVALID = 1'b1;
            wait_sig(1, "w");
            tick();
        end
        MIG_Port_WVALID = 1'b0; MIG_Port_WLAST = 1'b0; MIG_Port_BREADY = 1'b1;
        wait_sig(2, "b");
        resp = MIG_Port_BRESP;
        tick();
        MIG_Port_BREADY = 1'b0;
    endtask

    logic [DW-1:0] rd_data [256];
    logic [1:0]    rd_resp [256];
    logic          rd_last [256];

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [3:0] pat,
                            output int lat, output int nb, output int span);
        int cyc = 0, k = 0;
        bit stalled = 0;
        logic [DW-1:0] sd = '0;
        logic sl = 1'b0;
        lat = 0; nb = 0; span = 0;
        MIG_Port_ARID = id; MIG_Port_ARADDR = addr; MIG_Port_ARLEN = len;
        MIG_Port_ARSIZE = size; MIG_Port_ARBURST = 2'b01; MIG_Port_ARVALID = 1'b1;
        wait_sig(3, "ar");
        tick();
        MIG_Port_ARVALID = 1'b0;
        MIG_Port_RREADY = pat[0];
        while (nb <= int'(len) && cyc < 2000) begin
            @(negedge aclk);
            cyc++;
            if (MIG_Port_RVALID) begin
                if (lat == 0) lat = cyc;
                if (stalled) begin
                    check("r_stall_data", MIG_Port_RDATA, sd);
                    check_int("r_stall_last", int'(MIG_Port_RLAST), int'(sl));
                end
                stalled = !MIG_Port_RREADY;
                sd = MIG_Port_RDATA; sl = MIG_Port_RLAST;
                if (MIG_Port_RREADY) begin
                    rd_data[nb] = MIG_Port_RDATA; rd_resp[nb] = MIG_Port_RRESP;
                    rd_last[nb] = MIG_Port_RLAST;
                    nb++;
                    span = cyc - lat + 1;
                end
                k++;
            end
            tick();
            MIG_Port_RREADY = pat[k % 4];
        end
        MIG_Port_RREADY = 1'b0;
        if (nb <= int'(len)) begin
            checks++; errors++;
            $display("FAIL r_timeout: got %0d beats, expected %0d", nb, int'(len) + 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] resp;
        int lat, nb, span;
        #2 aresetn = 1'b0;
        repeat (3) tick();
        MIG_Port_AWVALID = 1'b1;
        aresetn = 1'b1;
        repeat (15) tick();
        check_int("calib_15", int'(init_calib), 0);
        check_int("awready_15", int'(MIG_Port_AWREADY), 0);
        tick();
        check_int("calib_16", int'(init_calib), 1);
        check_int("awready_16", int'(MIG_Port_AWREADY), 1);

        wr_burst(4'h5, 32'h40, 8'd3, 4, 128'd1, 16'hFFFF, 2'b01, resp);
        check_int("wr_okay", int'(resp), 0);
        rd_burst(4'h6, 32'h40, 8'd3, 3'd4, 4'hF, lat, nb, span);
        check_int("rd_latency", lat, 2);
        check_int("rd_beats", nb, 4);
        for (int n = 0; n < 4; n++) check("rd_incr_data", rd_data[n], DW'(n + 1));
        check_int("rd_last3", int'(rd_last[3]), 1);
        check_int("rd_last2", int'(rd_last[2]), 0);

        wr_burst(4'h1, 32'h100, 8'd0, 1, '0, 16'hFFFF, 2'b01, resp);
        wr_burst(4'h2, 32'h100, 8'd0, 1, '1, 16'h000F, 2'b01, resp);
        rd_burst(4'h3, 32'h100, 8'd0, 3'd4, 4'hF, lat, nb, span);
        check("partial_strobe", rd_data[0], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        check_int("partial_last", int'(rd_last[0]), 1);

        wr_burst(4'h4, 32'h200, 8'd3, 4, 128'hA0, 16'hFFFF, 2'b01, resp);
        rd_burst(4'h4, 32'h200, 8'd3, 3'd4, 4'b1001, lat, nb, span);
        check_int("stall_beats", nb, 4);
        for (int n = 0; n < 4; n++) check("stall_data", rd_data[n], DW'(32'hA0 + n));

        wr_burst(4'h7, 32'h3FF0, 8'd1, 2, 128'hABCD, 16'hFFFF, 2'b01, resp);
        check_int("edge_bresp", int'(resp), 3);
        rd_burst(4'h8, 32'h3FF0, 8'd1, 3'd4, 4'hF, lat, nb, span);
        check("edge_data0", rd_data[0], 128'hABCD);
        check_int("edge_resp0", int'(rd_resp[0]), 0);
        check("edge_data1", rd_data[1], '0);
        check_int("edge_resp1", int'(rd_resp[1]), 3);

        wr_burst(4'h9, 32'h300, 8'd3, 2, 128'h50, 16'hFFFF, 2'b01, resp);
        check_int("early_wlast", int'(resp), 2);

        wr_burst(4'hA, 32'h400, 8'd1, 2, 128'h60, 16'hFFFF, 2'b00, resp);
        check_int("fixed_bresp", int'(resp), 2);
        rd_burst(4'hB, 32'h400, 8'd1, 3'd3, 4'hF, lat, nb, span);
        check_int("size_rresp", int'(rd_resp[0]), 2);
        check("size_data1", rd_data[1], 128'h61);

        wr_burst(4'hC, 32'h1000, 8'd255, 256, 128'h1000, 16'hFFFF, 2'b01, resp);
        check_int("len255_bresp", int'(resp), 0);
        rd_burst(4'hD, 32'h1000, 8'd255, 3'd4, 4'hF, lat, nb, span);
        check_int("len255_beats", nb, 256);
        check_int("len255_span", span, 256);
        check("len255_data", rd_data[255], 128'h10FF);
        check_int("len255_last", int'(rd_last[255]), 1);
        check_int("len255_notlast", int'(rd_last[254]), 0);

        MIG_Port_ARID = 4'hE; MIG_Port_ARADDR = 32'h1000; MIG_Port_ARLEN = 8'd7;
        MIG_Port_ARSIZE = 3'd4; MIG_Port_ARVALID = 1'b1;
        wait_sig(3, "ar_rst");
        tick();
        MIG_Port_ARVALID = 1'b0;
        tick();
        tick();
        check_int("rvalid_before_rst", int'(MIG_Port_RVALID), 1);
        aresetn = 1'b0;
        #1;
        check_int("rvalid_in_rst", int'(MIG_Port_RVALID), 0);
        check_int("calib_in_rst", int'(init_calib), 0);
        repeat (2) tick();
        aresetn = 1'b1;
        rd_burst(4'hF, 32'h40, 8'd3, 3'd4, 4'hF, lat, nb, span);
        check_int("post_rst_latency", lat, 2);
        for (int n = 0; n < 4; n++) check("post_rst_data", rd_data[n], DW'(n + 1));

        repeat (4) tick();
        check_int("rq_drained", rq.size(), 0);
        check_int("bq_drained", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
